// File: rtl/dmem_resp.sv
// rtl/dmem_resp.sv - multi-cycle data-memory responder; DMEM_POSTED_WR_EN enables posted writes
module dmem_resp #(
    parameter int DEPTH = 1024,
    parameter int LAT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        re,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wrt_data,
    output logic [15:0] rd_data,
    output logic        rd_vld,
    output logic        stall,
    output logic        conflict
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    cnt;
    logic [3:0]    cnt_nxt;
    logic          accept;
    logic          commit;

    // Registered copy of the accepted request. In the posted build this is
    // also the single-entry write buffer that drains during BUSY.
    logic [AW-1:0] idx_q;
    logic [15:0]   data_q;
    logic          wr_q;

    logic [15:0]   mem [DEPTH];

    // Upper address bits select nothing; the word index wraps.
    logic          unused_addr;
    assign unused_addr = ^addr[15:AW];

    // Next-state and countdown; accept only from IDLE, commit when the count expires.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (re | we) begin
                    accept    = 1'b1;
                    cnt_nxt   = CNT_INIT;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    commit = 1'b1;
`ifdef DMEM_POSTED_WR_EN
                    // A posted write was already released to the pipeline, so
                    // there is no request left to release in a DONE cycle.
                    state_nxt = wr_q ? IDLE : DONE;
`else
                    state_nxt = DONE;
`endif
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Stall holds the pipeline until the DONE cycle releases it.
    always_comb begin
`ifdef DMEM_POSTED_WR_EN
        // A write seen in IDLE goes straight into the buffer and does not stall;
        // anything arriving while the buffer drains waits for the commit.
        if (state == IDLE) begin
            stall = re & ~we;
        end else begin
            stall = (re | we) & (state != DONE);
        end
`else
        stall = (re | we) & (state != DONE);
`endif
    end

    // Control state, request capture and read-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            idx_q    <= '0;
            data_q   <= 16'h0000;
            wr_q     <= 1'b0;
            rd_data  <= 16'h0000;
            rd_vld   <= 1'b0;
            conflict <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            rd_vld   <= commit & ~wr_q;
            conflict <= accept & re & we;
            if (accept) begin
                idx_q  <= addr[AW-1:0];
                data_q <= wrt_data;
                wr_q   <= we;
            end
            if (commit & ~wr_q) begin
                rd_data <= mem[idx_q];
            end
        end
    end

    // Memory array is not reset; a reset during BUSY leaves state IDLE so the
    // aborted write never reaches the array.
    always_ff @(posedge clk) begin
        if (commit & wr_q) begin
            mem[idx_q] <= data_q;
        end
    end

endmodule

// File: tb/tb_dmem_resp.sv
// tb/tb_dmem_resp.sv - self-checking bench for dmem_resp with a transaction-level memory model
`timescale 1ns/1ps
module tb_dmem_resp;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        re;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wrt_data;
    logic [15:0] rd_data;
    logic        rd_vld;
    logic        stall;
    logic        conflict;

    dmem_resp #(.DEPTH(1024), .LAT(LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .re       (re),
        .we       (we),
        .addr     (addr),
        .wrt_data (wrt_data),
        .rd_data  (rd_data),
        .rd_vld   (rd_vld),
        .stall    (stall),
        .conflict (conflict)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference model: word array indexed by addr[9:0], last value read out.
    logic [15:0] model_mem [1024];
    bit          written   [1024];
    logic [15:0] last_rd = 16'h0000;
    bit          pend_wr = 0;

    int          vld_cnt;
    int          cf_cnt;
    logic        adv_vld;
    logic [15:0] adv_data;

    function automatic void model_access(input logic w, input logic [15:0] a, input logic [15:0] d);
        if (w) begin
            model_mem[a[9:0]] = d;
            written[a[9:0]]   = 1'b1;
        end else begin
            last_rd = model_mem[a[9:0]];
        end
    endfunction

    // Cycles the pipeline is held for a request, given whether a posted write
    // was handed over in the cycle just before.
    function automatic int exp_stall(input logic w, input bit pend);
        int s;
`ifdef DMEM_POSTED_WR_EN
        s = pend ? LAT : 0;
        if (!w) s += LAT + 1;
`else
        s = LAT + 1;
`endif
        return s;
    endfunction

    // Present a request, hold it while stalled, release it after the advance edge.
    task automatic txn(input logic r, input logic w, input logic [15:0] a,
                       input logic [15:0] a2, input logic [15:0] d, output int scyc);
        re = r; we = w; addr = a; wrt_data = d;
        scyc = 0; vld_cnt = 0; cf_cnt = 0; adv_vld = 1'b0; adv_data = 16'h0000;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            vld_cnt += int'(rd_vld);
            cf_cnt  += int'(conflict);
            if (!stall) begin
                adv_vld  = rd_vld;
                adv_data = rd_data;
                break;
            end
            scyc++;
            @(posedge clk); #1;
            addr = a2;
        end
        @(posedge clk); #1;
        re = 1'b0; we = 1'b0;
        pend_wr = w;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            vld_cnt += int'(rd_vld);
            cf_cnt  += int'(conflict);
        end
        @(posedge clk); #1;
        pend_wr = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; re = 1'b1; we = 1'b0; addr = 16'h0; wrt_data = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL reset_stall_follows_re: got %b expected 1", stall); end
        checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0000", rd_data); end
        checks++; if (rd_vld !== 1'b0) begin errors++; $display("FAIL reset_rd_vld: got %b expected 0", rd_vld); end
        checks++; if (conflict !== 1'b0) begin errors++; $display("FAIL reset_conflict: got %b expected 0", conflict); end
        re = 1'b0; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall_idle: got %b expected 0", stall); end
        @(posedge clk); #1;
        rst = 1'b0;
        last_rd = 16'h0;
    endtask

    task automatic test_write_read();
        int s;
        txn(1'b0, 1'b1, 16'd5, 16'd5, 16'hBEEF, s);
        model_access(1'b1, 16'd5, 16'hBEEF);
        idle(LAT + 2);
        checks++; if (s != exp_stall(1'b1, 0)) begin errors++; $display("FAIL wr_stall_cycles: got %0d expected %0d", s, exp_stall(1'b1, 0)); end
        checks++; if (vld_cnt != 0) begin errors++; $display("FAIL wr_rd_vld_count: got %0d expected 0", vld_cnt); end
        txn(1'b1, 1'b0, 16'd5, 16'd5, 16'h0, s);
        model_access(1'b0, 16'd5, 16'h0);
        idle(LAT + 2);
        checks++; if (s != LAT + 1) begin errors++; $display("FAIL rd_stall_cycles: got %0d expected %0d", s, LAT + 1); end
        checks++; if (adv_vld !== 1'b1) begin errors++; $display("FAIL rd_vld_at_advance: got %b expected 1", adv_vld); end
        checks++; if (adv_data !== 16'hBEEF) begin errors++; $display("FAIL rd_data_beef: got %h expected beef", adv_data); end
        checks++; if (vld_cnt != 1) begin errors++; $display("FAIL rd_vld_single_pulse: got %0d expected 1", vld_cnt); end
    endtask

    task automatic test_busy_change();
        int s;
        txn(1'b0, 1'b1, 16'd6, 16'd6, 16'h6666, s);
        model_access(1'b1, 16'd6, 16'h6666);
        idle(LAT + 2);
        txn(1'b1, 1'b0, 16'd5, 16'd6, 16'h0, s);
        model_access(1'b0, 16'd5, 16'h0);
        idle(LAT + 2);
        checks++; if (adv_data !== last_rd) begin errors++; $display("FAIL busy_addr_change: got %h expected %h", adv_data, last_rd); end
    endtask

    task automatic test_conflict();
        int s;
        logic [15:0] held;
        held = last_rd;
        txn(1'b1, 1'b1, 16'd7, 16'd7, 16'h1234, s);
        model_access(1'b1, 16'd7, 16'h1234);
        idle(LAT + 2);
        checks++; if (s != exp_stall(1'b1, 0)) begin errors++; $display("FAIL conflict_stall_cycles: got %0d expected %0d", s, exp_stall(1'b1, 0)); end
        checks++; if (cf_cnt != 1) begin errors++; $display("FAIL conflict_pulse_count: got %0d expected 1", cf_cnt); end
        checks++; if (vld_cnt != 0) begin errors++; $display("FAIL conflict_rd_vld: got %0d expected 0", vld_cnt); end
        checks++; if (rd_data !== held) begin errors++; $display("FAIL conflict_rd_data_held: got %h expected %h", rd_data, held); end
        txn(1'b1, 1'b0, 16'd7, 16'd7, 16'h0, s);
        model_access(1'b0, 16'd7, 16'h0);
        idle(LAT + 2);
        checks++; if (adv_data !== 16'h1234) begin errors++; $display("FAIL conflict_mem_value: got %h expected 1234", adv_data); end
    endtask

    task automatic test_reset_midrun();
        int k;
        int s;
        re = 1'b1; we = 1'b0; addr = 16'd5;
        for (k = 0; k < 64; k++) begin
            @(negedge clk);
            if (!stall) break;
        end
        checks++; if (k >= 64) begin errors++; $display("FAIL midrun_wait_done: got %0d cycles expected < 64", k); end
        #1 rst = 1'b1;
        #1;
        checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL midrun_rd_data: got %h expected 0000", rd_data); end
        checks++; if (rd_vld !== 1'b0) begin errors++; $display("FAIL midrun_rd_vld: got %b expected 0", rd_vld); end
        checks++; if (conflict !== 1'b0) begin errors++; $display("FAIL midrun_conflict: got %b expected 0", conflict); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL midrun_stall: got %b expected 1", stall); end
        re = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        last_rd = 16'h0;
        txn(1'b1, 1'b0, 16'd5, 16'd5, 16'h0, s);
        model_access(1'b0, 16'd5, 16'h0);
        idle(LAT + 2);
        checks++; if (s != LAT + 1) begin errors++; $display("FAIL midrun_idle_after: got %0d expected %0d", s, LAT + 1); end
        checks++; if (adv_data !== 16'hBEEF) begin errors++; $display("FAIL midrun_read_back: got %h expected beef", adv_data); end
    endtask

    task automatic test_reset_abort();
        int s;
        txn(1'b0, 1'b1, 16'd9, 16'd9, 16'h0001, s);
        model_access(1'b1, 16'd9, 16'h0001);
        idle(LAT + 2);
        re = 1'b0; we = 1'b1; addr = 16'd9; wrt_data = 16'hAAAA;
        @(posedge clk); #1;
        rst = 1'b1; we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        last_rd = 16'h0;
        idle(2);
        txn(1'b1, 1'b0, 16'd9, 16'd9, 16'h0, s);
        model_access(1'b0, 16'd9, 16'h0);
        idle(LAT + 2);
        checks++; if (adv_data !== 16'h0001) begin errors++; $display("FAIL abort_mem_unchanged: got %h expected 0001", adv_data); end
    endtask

    task automatic test_back_to_back();
        logic        r_l [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [15:0] a_l [5] = '{16'd3, 16'd3, 16'd3, 16'd4, 16'd4};
        logic [15:0] d_l [5] = '{16'hC3C3, 16'h0, 16'h0, 16'h4B4B, 16'h0};
        int s, e, c0, total;
        bit pend;
        total = 0;
        c0 = cyc;
        for (int i = 0; i < 5; i++) begin
            pend = pend_wr;
            e = exp_stall(!r_l[i], pend);
            total += e + 1;
            txn(r_l[i], !r_l[i], a_l[i], a_l[i], d_l[i], s);
            model_access(!r_l[i], a_l[i], d_l[i]);
            checks++; if (s != e) begin errors++; $display("FAIL b2b_stall_%0d: got %0d expected %0d", i, s, e); end
            if (r_l[i]) begin
                checks++; if (adv_data !== last_rd) begin errors++; $display("FAIL b2b_data_%0d: got %h expected %h", i, adv_data, last_rd); end
            end
        end
        checks++; if (cyc - c0 != total) begin errors++; $display("FAIL b2b_total_cycles: got %0d expected %0d", cyc - c0, total); end
        idle(LAT + 2);
    endtask

    task automatic test_random();
        int s;
        logic r, w;
        logic [15:0] a, d;
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom());
            a[9:0] = 10'($urandom_range(0, 15));
            d = 16'($urandom());
            r = 1'($urandom_range(0, 1));
            w = !r;
            if (r && !written[a[9:0]]) begin r = 1'b0; w = 1'b1; end
            if ($urandom_range(0, 7) == 0) begin r = 1'b1; w = 1'b1; end
            txn(r, w, a, a, d, s);
            model_access(w, a, d);
            idle(LAT + 2);
            checks++; if (s != exp_stall(w, 0)) begin errors++; $display("FAIL rand_stall_%0d: got %0d expected %0d", i, s, exp_stall(w, 0)); end
            checks++; if (vld_cnt != int'(r & !w)) begin errors++; $display("FAIL rand_vld_%0d: got %0d expected %0d", i, vld_cnt, int'(r & !w)); end
            checks++; if (cf_cnt != int'(r & w)) begin errors++; $display("FAIL rand_conflict_%0d: got %0d expected %0d", i, cf_cnt, int'(r & w)); end
            checks++; if (rd_data !== last_rd) begin errors++; $display("FAIL rand_rd_data_%0d: got %h expected %h", i, rd_data, last_rd); end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_busy_change();
        test_conflict();
        test_reset_midrun();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
